// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - word-addressed scratch memory slave on the req/ack bus
module bus_slave_mem #(
    parameter int SLAVE_ID = 0,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;
    localparam logic [3:0] LAT_LOAD   = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          cmd_q, cmd_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];

    logic          hit;
    logic          enter_ack;
    logic          op_cmd;
    logic [AW-1:0] op_idx;
    logic [31:0]   op_wdata;
    logic          unused_addr;

    assign hit         = req && (addr[31] == 1'(SLAVE_ID));
    assign unused_addr = ^{addr[30:AW+2], addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    cmd_d   = cmd;
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    cnt_d   = LAT_LOAD;
                    busy_d  = 1'b1;
                    state_d = (LATENCY == 1) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: state_d = ST_RELEASE;
            ST_RELEASE: begin
                // A master holding req until it sees ack fall must not be re-accepted.
                if (!req) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With single-cycle latency the access happens on the accept edge, so use live inputs.
    always_comb begin
        enter_ack = (state_d == ST_ACK);
        op_cmd    = (state_q == ST_IDLE) ? cmd          : cmd_q;
        op_idx    = (state_q == ST_IDLE) ? addr[AW+1:2] : idx_q;
        op_wdata  = (state_q == ST_IDLE) ? wdata        : wdata_q;
        mem_d     = mem_q;
        ack_d     = enter_ack;
        rdata_d   = rdata_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (enter_ack) begin
            if (op_cmd) begin
                mem_d[op_idx] = op_wdata;
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                rdata_d = mem_q[op_idx];
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            cmd_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
            busy_q   <= 1'b0;
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            mem_q    <= mem_d;
        end
    end

    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// tb/tb_bus_slave_mem.sv - scoreboard bench: two slaves (id0 lat2, id1 lat1) on a shared bus
module tb_bus_slave_mem;

    localparam int DEPTH = 16;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic        clk = 1'b0;
    logic        rst, req, cmd;
    logic [31:0] addr, wdata;
    logic        ack0, ack1, busy0, busy1;
    logic [31:0] rdata0, rdata1;
    logic [15:0] wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1;

    bus_slave_mem #(.SLAVE_ID(0), .DEPTH(DEPTH), .AW(4), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack0), .rdata(rdata0), .busy(busy0), .wr_cnt(wr_cnt0), .rd_cnt(rd_cnt0)
    );
    bus_slave_mem #(.SLAVE_ID(1), .DEPTH(DEPTH), .AW(4), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack1), .rdata(rdata1), .busy(busy1), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] wr;
        logic [15:0] rd;
        int          ack_cyc;
    } exp_t;

    exp_t        exp_q [2][$];
    exp_t        mon_e;
    logic [31:0] mem_m   [2][DEPTH];
    logic [15:0] wr_m    [2];
    logic [15:0] rd_m    [2];
    logic [31:0] last_rd [2];
    int          checks = 0;
    int          errors = 0;

    function automatic logic f_ack(int s);
        return (s == 1) ? ack1 : ack0;
    endfunction
    function automatic logic f_busy(int s);
        return (s == 1) ? busy1 : busy0;
    endfunction
    function automatic logic [31:0] f_rdata(int s);
        return (s == 1) ? rdata1 : rdata0;
    endfunction
    function automatic logic [15:0] f_wr(int s);
        return (s == 1) ? wr_cnt1 : wr_cnt0;
    endfunction
    function automatic logic [15:0] f_rd(int s);
        return (s == 1) ? rd_cnt1 : rd_cnt0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[s][i] = 32'd0;
            wr_m[s]    = 16'd0;
            rd_m[s]    = 16'd0;
            last_rd[s] = 32'd0;
        end
    endtask

    // Drive one transaction from a negedge with both slaves idle; expectation goes to the scoreboard.
    task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d, input int hold);
        int   s;
        int   idx;
        bit   got;
        exp_t e;
        s   = int'(a[31]);
        idx = int'((a >> 2) % 32'(DEPTH));
        if (c) begin
            mem_m[s][idx] = d;
            if (wr_m[s] != 16'hFFFF) wr_m[s] = wr_m[s] + 16'd1;
        end else begin
            last_rd[s] = mem_m[s][idx];
            if (rd_m[s] != 16'hFFFF) rd_m[s] = rd_m[s] + 16'd1;
        end
        e.rdata   = last_rd[s];
        e.wr      = wr_m[s];
        e.rd      = rd_m[s];
        e.ack_cyc = cyc + ((s == 1) ? LAT1 : LAT0);
        exp_q[s].push_back(e);
        req = 1'b1; cmd = c; addr = a; wdata = d;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = f_ack(s);
        end
        if (!got) begin
            chk($sformatf("ack_timeout_s%0d", s), 32'd0, 32'd1);
            exp_q[s].delete();
        end
        repeat (hold) @(negedge clk);
        chk($sformatf("other_busy_s%0d", 1 - s), 32'(f_busy(1 - s)), 32'd0);
        req = 1'b0; cmd = 1'($urandom); addr = $urandom; wdata = $urandom;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = !f_busy(s);
        end
        if (!got) chk($sformatf("release_timeout_s%0d", s), 32'd1, 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int s = 0; s < 2; s++) begin
                    if (f_ack(s)) begin
                        if (exp_q[s].size() == 0) begin
                            chk($sformatf("spurious_ack_s%0d", s), 32'd1, 32'd0);
                        end else begin
                            mon_e = exp_q[s].pop_front();
                            chk($sformatf("rdata_s%0d", s), f_rdata(s), mon_e.rdata);
                            chk($sformatf("wr_cnt_s%0d", s), 32'(f_wr(s)), 32'(mon_e.wr));
                            chk($sformatf("rd_cnt_s%0d", s), 32'(f_rd(s)), 32'(mon_e.rd));
                            chk($sformatf("ack_cycle_s%0d", s), 32'(cyc), 32'(mon_e.ack_cyc));
                            chk($sformatf("busy_at_ack_s%0d", s), 32'(f_busy(s)), 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b0; req = 1'b1; cmd = 1'b1; addr = 32'h0000_0010; wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_ack_s%0d", s), 32'(f_ack(s)), 32'd0);
            chk($sformatf("rst_busy_s%0d", s), 32'(f_busy(s)), 32'd0);
            chk($sformatf("rst_wr_s%0d", s), 32'(f_wr(s)), 32'd0);
            chk($sformatf("rst_rd_s%0d", s), 32'(f_rd(s)), 32'd0);
            chk($sformatf("rst_rdata_s%0d", s), f_rdata(s), 32'd0);
        end
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        txn(1'b1, 32'h0000_0CE0, 32'h0000_0345, 0);
        txn(1'b0, 32'h0000_0CE0, 32'd0, 0);
        txn(1'b1, 32'h8000_0040, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'h8000_0000, 32'd0, 0);
        txn(1'b0, 32'h8000_0004, 32'd0, 20);
        txn(1'b1, 32'h0000_0010, 32'h0000_A5A5, 5);
        txn(1'b0, 32'h0000_0010, 32'd0, 1);

        // Abort a slave-0 write while it sits in WAIT.
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_0014; wdata = 32'h1234_5678;
        @(negedge clk);
        chk("mid_busy_s0", 32'(busy0), 32'd1);
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("mid_ack_s0", 32'(ack0), 32'd0);
        chk("mid_busy_after_s0", 32'(busy0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        txn(1'b0, 32'h0000_0014, 32'd0, 0);

        for (int n = 0; n < 150; n++) begin
            txn(1'($urandom), {1'($urandom), 31'($urandom)}, $urandom, int'($urandom_range(0, 5)));
        end

        force dut1.rd_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut1.rd_cnt_q;
        rd_m[1] = 16'hFFFE;
        for (int n = 0; n < 3; n++) txn(1'b0, {1'b1, 31'($urandom)}, 32'd0, 0);
        chk("rd_cnt_sat_s1", 32'(rd_cnt1), 32'h0000_FFFF);
        chk("queue_drained_s0", 32'(exp_q[0].size()), 32'd0);
        chk("queue_drained_s1", 32'(exp_q[1].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
